// File: rtl/gpl_pkg.sv
//------------------------------------------------------------------------------
// Module      : gpl_pkg
// Description : Shared definitions for the GPL status filter: debounce FSM
//               state encoding, default filter constants and a small decode
//               helper for the debounced level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpl_pkg;

  // Default sample-tick period in clk cycles.
  localparam int c_PRESC_DIV_DEF = 10;
  // Default number of consecutive equal samples needed to change state.
  localparam int c_DEB_LEN_DEF   = 4;

  // Debounce FSM states. Bit 1 carries the debounced level, so the two
  // "currently high" states (HIGH, FALL_CHK) share the upper bit.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  // Debounced level associated with a state.
  function automatic logic f_is_high(input state_t s);
    return (s == HIGH) || (s == FALL_CHK);
  endfunction

endpackage : gpl_pkg

`default_nettype wire

// File: rtl/gpl_sync2.sv
//------------------------------------------------------------------------------
// Module      : gpl_sync2
// Description : Two-flop synchronizer bringing an asynchronous single-bit
//               signal into the clk domain.
// Ports       : clk     - system clock, rising edge
//               arst    - asynchronous reset, active-high, clears both stages
//               i_async - asynchronous input
//               o_sync  - synchronized output (second flop stage)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpl_sync2 (
  input  logic clk,
  input  logic arst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : gpl_sync2

`default_nettype wire

// File: rtl/gpl_status_filter.sv
//------------------------------------------------------------------------------
// Module      : gpl_status_filter
// Description : Debounce filter for the raw GPL status line. The raw input is
//               synchronized, sampled once every PRESC_DIV cycles and must be
//               seen at the new level on DEB_LEN consecutive samples before
//               the debounced status changes. Edge pulses and a sample strobe
//               are provided for the downstream status FSM.
// Parameters  : PRESC_DIV  - sample-tick period in clk cycles (2..1024)
//               DEB_LEN    - consecutive equal samples to change (1..255)
// Ports       : clk        - system clock, rising edge
//               arst       - asynchronous reset, active-high
//               gpl_raw    - raw GPL status line, asynchronous
//               filt_en    - filter enable, 0 freezes the filter
//               gpl_status - debounced status
//               ena        - one-cycle sample strobe (tick delayed by one)
//               rise_pulse - one-cycle pulse on gpl_status 0->1
//               fall_pulse - one-cycle pulse on gpl_status 1->0
//               glitch_cnt - saturating count of rejected glitches
// Build macro : GPL_FILT_GLITCH_CNT_EN - when defined, the glitch counter is
//               built; otherwise glitch_cnt is tied to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpl_status_filter
  import gpl_pkg::*;
#(
  parameter int PRESC_DIV = c_PRESC_DIV_DEF,
  parameter int DEB_LEN   = c_DEB_LEN_DEF
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       gpl_raw,
  input  logic       filt_en,
  output logic       gpl_status,
  output logic       ena,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt
);

  localparam int PW = $clog2(PRESC_DIV);
  localparam int DW = $clog2(DEB_LEN + 1);

  localparam logic [PW-1:0] c_PRESC_MAX = PW'(PRESC_DIV - 1);
  localparam logic [PW-1:0] c_PRESC_ONE = PW'(1);
  localparam logic [DW-1:0] c_DEB_LEN   = DW'(DEB_LEN);
  localparam logic [DW-1:0] c_DEB_ONE   = DW'(1);

  //--------------------------------------------------------------------------
  // Input synchronizer
  //--------------------------------------------------------------------------
  logic w_gpl_sync;

  gpl_sync2 u_sync2 (
    .clk     (clk),
    .arst    (arst),
    .i_async (gpl_raw),
    .o_sync  (w_gpl_sync)
  );

  //--------------------------------------------------------------------------
  // Sample prescaler: counts 0..PRESC_DIV-1 while enabled, parked at 0 while
  // disabled so a re-enable always yields a full period before the next tick.
  //--------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = filt_en && (r_presc == c_PRESC_MAX);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_presc <= '0;
    end else if (!filt_en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_PRESC_ONE;
    end
  end

  logic r_ena;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ena <= 1'b0;
    end else begin
      r_ena <= w_tick;
    end
  end

  assign ena = r_ena;

  //--------------------------------------------------------------------------
  // Debounce FSM. Transitions only happen on a tick, so holding filt_en low
  // freezes the state and the debounce count.
  //--------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] w_deb_cnt_nxt;
  logic [DW-1:0] w_deb_cnt_inc;
  logic          w_glitch;

  // Only evaluated in the CHK states where r_deb_cnt < DEB_LEN, so the
  // increment cannot wrap.
  assign w_deb_cnt_inc = r_deb_cnt + c_DEB_ONE;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= LOW;
      r_deb_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_cnt_nxt = r_deb_cnt;
    w_glitch      = 1'b0;

    if (w_tick) begin
      unique case (r_state)
        LOW: begin
          if (w_gpl_sync) begin
            if (c_DEB_LEN == c_DEB_ONE) begin
              w_state_nxt = HIGH;
            end else begin
              w_state_nxt   = RISE_CHK;
              w_deb_cnt_nxt = c_DEB_ONE;
            end
          end
        end

        RISE_CHK: begin
          if (w_gpl_sync) begin
            if (w_deb_cnt_inc == c_DEB_LEN) begin
              w_state_nxt   = HIGH;
              w_deb_cnt_nxt = '0;
            end else begin
              w_deb_cnt_nxt = w_deb_cnt_inc;
            end
          end else begin
            w_state_nxt   = LOW;
            w_deb_cnt_nxt = '0;
            w_glitch      = 1'b1;
          end
        end

        HIGH: begin
          if (!w_gpl_sync) begin
            if (c_DEB_LEN == c_DEB_ONE) begin
              w_state_nxt = LOW;
            end else begin
              w_state_nxt   = FALL_CHK;
              w_deb_cnt_nxt = c_DEB_ONE;
            end
          end
        end

        FALL_CHK: begin
          if (!w_gpl_sync) begin
            if (w_deb_cnt_inc == c_DEB_LEN) begin
              w_state_nxt   = LOW;
              w_deb_cnt_nxt = '0;
            end else begin
              w_deb_cnt_nxt = w_deb_cnt_inc;
            end
          end else begin
            w_state_nxt   = HIGH;
            w_deb_cnt_nxt = '0;
            w_glitch      = 1'b1;
          end
        end

        default: begin
          w_state_nxt   = LOW;
          w_deb_cnt_nxt = '0;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Status and edge pulses. The status is the upper state bit, i.e. straight
  // from a flop. The pulses are registered from the next-state decode so they
  // rise on the same edge as the status change.
  //--------------------------------------------------------------------------
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= f_is_high(w_state_nxt) && !f_is_high(r_state);
      r_fall <= !f_is_high(w_state_nxt) && f_is_high(r_state);
    end
  end

  assign gpl_status = f_is_high(r_state);
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

  //--------------------------------------------------------------------------
  // Optional glitch counter, saturating at 255. Glitch events can only occur
  // on a tick, but the counter itself is not gated by filt_en.
  //--------------------------------------------------------------------------
`ifdef GPL_FILT_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  logic w_glitch_unused;

  assign w_glitch_unused = w_glitch;
  assign glitch_cnt      = 8'd0;
`endif

endmodule : gpl_status_filter

`default_nettype wire

// File: tb/tb_gpl_status_filter.sv
//------------------------------------------------------------------------------
// Module      : tb_gpl_status_filter
// Description : Self-checking bench for gpl_status_filter (PRESC_DIV=4,
//               DEB_LEN=3). A behavioural model tracks the expected outputs
//               each cycle; directed scenarios add literal expectations and a
//               randomized phase exercises raw/enable/reset combinations.
//               Honours GPL_FILT_GLITCH_CNT_EN for glitch_cnt expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpl_status_filter;

  localparam int P = 4;
  localparam int D = 3;

`ifdef GPL_FILT_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       arst    = 1'b1;
  logic       gpl_raw = 1'b1;
  logic       filt_en = 1'b1;
  logic       gpl_status;
  logic       ena;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpl_status_filter #(
    .PRESC_DIV (P),
    .DEB_LEN   (D)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .gpl_raw    (gpl_raw),
    .filt_en    (filt_en),
    .gpl_status (gpl_status),
    .ena        (ena),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  //--------------------------------------------------------------------------
  // Behavioural model. The filter is described as: a 2-cycle delayed copy of
  // the raw line, sampled once every P enabled cycles; the status flips once
  // D consecutive samples disagree with it, and a disagreeing run that is
  // broken before reaching D is a glitch.
  //--------------------------------------------------------------------------
  bit m_d1, m_d2;
  int m_en_run;
  bit m_status, m_ena, m_rise, m_fall;
  int m_run;
  int m_gc;
  bit s_sample, s_tick;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_d1 = 0; m_d2 = 0; m_en_run = 0;
      m_status = 0; m_ena = 0; m_rise = 0; m_fall = 0;
      m_run = 0; m_gc = 0;
    end else begin
      s_sample = m_d2;
      s_tick   = filt_en && ((m_en_run % P) == P - 1);
      m_d2     = m_d1;
      m_d1     = gpl_raw;
      m_en_run = filt_en ? m_en_run + 1 : 0;
      m_ena    = s_tick;
      m_rise   = 0;
      m_fall   = 0;
      if (s_tick) begin
        if (s_sample != m_status) begin
          m_run++;
          if (m_run == D) begin
            m_status = ~m_status;
            m_rise   = m_status;
            m_fall   = !m_status;
            m_run    = 0;
          end
        end else begin
          if (m_run > 0 && m_gc < 255) m_gc++;
          m_run = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("gpl_status", 32'(gpl_status), 32'(m_status));
    check("ena",        32'(ena),        32'(m_ena));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("glitch_cnt", 32'(glitch_cnt), GC_EN ? 32'(m_gc) : 32'd0);
  end

  //--------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the falling edge.
  //--------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ena();
    int k;
    for (k = 0; k < 50; k++) begin
      step();
      if (ena) break;
    end
    if (k == 50) begin
      checks++;
      errors++;
      $display("FAIL wait_ena timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, n, t;
    bit seen, seen2;
    int hold, en_hold;

    // Reset with raw high: all outputs low.
    @(negedge clk);
    check("rst_status", 32'(gpl_status), 32'd0);
    check("rst_ena",    32'(ena),        32'd0);
    check("rst_rise",   32'(rise_pulse), 32'd0);
    check("rst_fall",   32'(fall_pulse), 32'd0);
    check("rst_gcnt",   32'(glitch_cnt), 32'd0);
    step();
    arst    = 1'b0;
    gpl_raw = 1'b0;

    // First strobe in cycle 5 after release, then every 4 cycles.
    first = 0; second = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ena) begin
        if (first == 0) first = k + 1;
        else if (second == 0) second = k + 1;
      end
    end
    check("ena_first_cycle", 32'(first), 32'd5);
    check("ena_period",      32'(second - first), 32'd4);

    // Clean rise aligned right after a tick: 3 ticks of 4 cycles.
    wait_ena();
    gpl_raw = 1'b1;
    n = 0;
    while (!gpl_status && n < 40) begin step(); n++; end
    check("rise_latency", 32'(n), 32'd12);
    check("rise_pulse_at_edge", 32'(rise_pulse), 32'd1);
    step();
    check("rise_pulse_width", 32'(rise_pulse), 32'd0);

    // Clean fall: status drops on the 3rd tick.
    wait_ena();
    gpl_raw = 1'b0;
    t = 0; n = 0;
    while (gpl_status && n < 40) begin step(); n++; if (ena) t++; end
    check("fall_ticks", 32'(t), 32'd3);
    check("fall_pulse_at_edge", 32'(fall_pulse), 32'd1);

    // Glitch: high for a single tick only.
    wait_ena();
    gpl_raw = 1'b1;
    seen = 0;
    wait_ena();
    gpl_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin step(); if (rise_pulse) seen = 1; end
    check("glitch_status", 32'(gpl_status), 32'd0);
    check("glitch_no_rise", 32'(seen), 32'd0);
    check("glitch_cnt_one", 32'(glitch_cnt), GC_EN ? 32'd1 : 32'd0);

    // Freeze during RISE_CHK.
    wait_ena();
    gpl_raw = 1'b1;
    wait_ena();
    filt_en = 1'b0;
    seen = 0; seen2 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ena) seen = 1;
      if (gpl_status) seen2 = 1;
    end
    check("freeze_ena_silent", 32'(seen), 32'd0);
    check("freeze_status_low", 32'(seen2), 32'd0);
    filt_en = 1'b1;
    t = 0; n = 0;
    while (!gpl_status && n < 40) begin step(); n++; if (ena) t++; end
    check("resume_ticks", 32'(t), 32'd2);

    // Mid-debounce reset during a fall.
    wait_ena();
    gpl_raw = 1'b0;
    seen = 0;
    wait_ena(); if (fall_pulse) seen = 1;
    wait_ena(); if (fall_pulse) seen = 1;
    arst = 1'b1;
    #1;
    check("mid_rst_status", 32'(gpl_status), 32'd0);
    check("mid_rst_ena",    32'(ena),        32'd0);
    step(); step();
    arst = 1'b0;
    for (int k = 0; k < 16; k++) begin step(); if (fall_pulse) seen = 1; end
    check("mid_rst_no_fall", 32'(seen), 32'd0);
    check("mid_rst_status_after", 32'(gpl_status), 32'd0);

    // Saturation of the glitch counter.
    wait_ena();
    for (int g = 0; g < 300; g++) begin
      gpl_raw = 1'b1;
      wait_ena();
      gpl_raw = 1'b0;
      wait_ena();
    end
    check("glitch_saturate", 32'(glitch_cnt), GC_EN ? 32'd255 : 32'd0);

    // Randomized phase.
    hold = 0; en_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        gpl_raw = 1'($urandom_range(0, 1));
        hold    = int'($urandom_range(1, 40));
      end
      hold--;
      if (en_hold == 0) begin
        filt_en = ($urandom_range(0, 9) != 0);
        en_hold = int'($urandom_range(1, 60));
      end
      en_hold--;
      arst = ($urandom_range(0, 799) == 0);
      step();
    end
    arst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpl_status_filter

`default_nettype wire
